// File: rtl/lb_eth_pkg.sv
// Shared Ethernet constants and the RX parser state type for lb_system.
// Contents: header/pad sizes, well-known addresses and ethertypes, the
// parser state enum, and a group-address test helper.
package lb_eth_pkg;

   localparam int          ETH_ALEN       = 6;
   localparam int          ETH_HDR_BYTES  = 14;
   localparam int          RX_PAD_BYTES   = 2;
   localparam logic [47:0] ETH_BCAST      = 48'hFFFF_FFFF_FFFF;
   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_H1,
      ST_H2,
      ST_H3,
      ST_HDR_WAIT,
      ST_PAYLOAD,
      ST_DROP
   } parser_state_e;

   // The I/G bit is the LSB of the first octet on the wire, which lands in
   // bit 40 of a MAC held MSB-first. Broadcast has it set as well.
   function automatic logic is_group_mac(input logic [47:0] mac);
      return mac[40];
   endfunction

endpackage

// File: rtl/st_reg_slice.sv
// One-stage Avalon-ST register slice for the parser payload path.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_valid/o_ready          upstream handshake (o_ready = i_ready || !o_valid)
//   i_data/sop/eop/empty/error  upstream beat
//   o_valid/i_ready          downstream handshake
//   o_data/sop/eop/empty/error  registered beat, held while o_valid && !i_ready
module st_reg_slice #(
   parameter int DATA_W  = 32,
   parameter int EMPTY_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [DATA_W-1:0]  i_data,
   input  logic               i_sop,
   input  logic               i_eop,
   input  logic [EMPTY_W-1:0] i_empty,
   input  logic               i_error,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [DATA_W-1:0]  o_data,
   output logic               o_sop,
   output logic               o_eop,
   output logic [EMPTY_W-1:0] o_empty,
   output logic               o_error
);

   logic               r_valid;
   logic [DATA_W-1:0]  r_data;
   logic               r_sop;
   logic               r_eop;
   logic [EMPTY_W-1:0] r_empty;
   logic               r_error;

   assign o_ready = i_ready || !r_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
         r_empty <= '0;
         r_error <= 1'b0;
      end else if (o_ready) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data  <= i_data;
            r_sop   <= i_sop;
            r_eop   <= i_eop;
            r_empty <= i_empty;
            r_error <= i_error;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_sop   = r_sop;
   assign o_eop   = r_eop;
   assign o_empty = r_empty;
   assign o_error = r_error;

endmodule

// File: rtl/eth_rx_parser.sv
// Ethernet RX parser between the MAC RX FIFO (32-bit Avalon-ST, shift16)
// and the load-balancer forwarding logic. Strips pad + 14-byte header,
// hands dst/src/ethertype off on a header handshake, then streams the
// word-aligned payload. Filters on dst MAC, drops runts, keeps saturating
// statistics.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_*                      RX stream from the MAC FIFO (byte 0 in [31:24])
//   local_mac, promisc        station address and promiscuous enable
//   hdr_*                     header handshake and fields
//   out_*                     payload stream (one register slice)
//   cnt_frames/runt/filtered  saturating statistics counters
module eth_rx_parser
   import lb_eth_pkg::*;
#(
   parameter int COUNTER_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_sop,
   input  logic                     in_eop,
   input  logic [1:0]               in_empty,
   input  logic                     in_error,
   input  logic [47:0]              local_mac,
   input  logic                     promisc,
   output logic                     hdr_valid,
   input  logic                     hdr_ready,
   output logic [47:0]              hdr_dst_mac,
   output logic [47:0]              hdr_src_mac,
   output logic [15:0]              hdr_ethertype,
   output logic [31:0]              out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_sop,
   output logic                     out_eop,
   output logic [1:0]               out_empty,
   output logic                     out_error,
   output logic [COUNTER_WIDTH-1:0] cnt_frames,
   output logic [COUNTER_WIDTH-1:0] cnt_runt,
   output logic [COUNTER_WIDTH-1:0] cnt_filtered
);

   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   parser_state_e            r_state, w_state_nxt;
   logic [47:0]              r_dst, r_src;
   logic [15:0]              r_type;
   logic                     r_hdr_valid;
   logic                     r_first;
   logic [COUNTER_WIDTH-1:0] r_cnt_frames, r_cnt_runt, r_cnt_filtered;
   logic                     w_in_ready, w_acc, w_pass, w_slice_rdy;
   logic                     w_runt, w_filt, w_hdr_take, w_slice_vld;

   assign w_in_ready = (r_state == ST_HDR_WAIT) ? 1'b0 :
                       (r_state == ST_PAYLOAD)  ? w_slice_rdy : 1'b1;
   assign w_acc      = in_valid && w_in_ready;
   assign w_pass     = promisc || (r_dst == local_mac) || is_group_mac(r_dst);
   assign w_hdr_take = r_hdr_valid && hdr_ready;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_runt      = 1'b0;
      w_filt      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_acc && in_sop) begin
               if (in_eop) w_runt = 1'b1;
               else        w_state_nxt = ST_H1;
            end
         end
         ST_H1, ST_H2, ST_H3: begin
            if (w_acc) begin
               if (in_sop) begin
                  // A fresh sop abandons the partial header and restarts at w0.
                  w_runt      = 1'b1;
                  w_state_nxt = in_eop ? ST_IDLE : ST_H1;
               end else if (in_eop) begin
                  w_runt      = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else if (r_state == ST_H1) begin
                  w_state_nxt = ST_H2;
               end else if (r_state == ST_H2) begin
                  w_state_nxt = ST_H3;
               end else if (w_pass) begin
                  w_state_nxt = ST_HDR_WAIT;
               end else begin
                  w_filt      = 1'b1;
                  w_state_nxt = ST_DROP;
               end
            end
         end
         ST_HDR_WAIT: if (w_hdr_take) w_state_nxt = ST_PAYLOAD;
         ST_PAYLOAD, ST_DROP: if (w_acc && in_eop) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dst          <= '0;
         r_src          <= '0;
         r_type         <= '0;
         r_hdr_valid    <= 1'b0;
         r_first        <= 1'b0;
         r_cnt_frames   <= '0;
         r_cnt_runt     <= '0;
         r_cnt_filtered <= '0;
      end else begin
         if (w_acc) begin
            if (in_sop && r_state != ST_PAYLOAD && r_state != ST_DROP)
               r_dst[47:32] <= in_data[15:0];
            else if (r_state == ST_H1)
               r_dst[31:0] <= in_data;
            else if (r_state == ST_H2)
               r_src[47:16] <= in_data;
            else if (r_state == ST_H3) begin
               r_src[15:0] <= in_data[31:16];
               r_type      <= in_data[15:0];
            end
         end
         if (r_state == ST_H3 && w_state_nxt == ST_HDR_WAIT) r_hdr_valid <= 1'b1;
         else if (w_hdr_take)                                 r_hdr_valid <= 1'b0;
         if (w_hdr_take)                             r_first <= 1'b1;
         else if (r_state == ST_PAYLOAD && w_acc)    r_first <= 1'b0;
         if (w_hdr_take) r_cnt_frames   <= sat_inc(r_cnt_frames);
         if (w_runt)     r_cnt_runt     <= sat_inc(r_cnt_runt);
         if (w_filt)     r_cnt_filtered <= sat_inc(r_cnt_filtered);
      end
   end

   assign w_slice_vld = in_valid && (r_state == ST_PAYLOAD);

   st_reg_slice #(.DATA_W(32), .EMPTY_W(2)) u_slice (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_slice_vld),
      .o_ready (w_slice_rdy),
      .i_data  (in_data),
      .i_sop   (r_first),
      .i_eop   (in_eop),
      .i_empty (in_eop ? in_empty : 2'd0),
      .i_error (in_eop && in_error),
      .o_valid (out_valid),
      .i_ready (out_ready),
      .o_data  (out_data),
      .o_sop   (out_sop),
      .o_eop   (out_eop),
      .o_empty (out_empty),
      .o_error (out_error)
   );

   assign in_ready      = w_in_ready;
   assign hdr_valid     = r_hdr_valid;
   assign hdr_dst_mac   = r_dst;
   assign hdr_src_mac   = r_src;
   assign hdr_ethertype = r_type;
   assign cnt_frames    = r_cnt_frames;
   assign cnt_runt      = r_cnt_runt;
   assign cnt_filtered  = r_cnt_filtered;

endmodule
